// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-master data memory arbiter with master-1 bus lock and tagged read return
module dmem_arbiter #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_m0_req,
  input  logic                         i_m0_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_m0_wdata,
  input  logic                         i_m1_req,
  input  logic                         i_m1_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_m1_wdata,
  input  logic                         i_m1_lock,
  output logic                         o_m0_gnt,
  output logic                         o_m1_gnt,
  output logic                         o_m0_rvalid,
  output logic                         o_m1_rvalid,
  output logic [P_DATA_WIDTH-1:0]      o_m0_rdata,
  output logic [P_DATA_WIDTH-1:0]      o_m1_rdata,
  output logic                         o_m0_stall,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [P_DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [P_DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0]      i_mem_rdata
);
  logic r_last_gnt, r_lock, r_rd_pend, r_rd_owner;
  always_comb begin
    o_m1_gnt    = ~i_rst & i_m1_req & (~i_m0_req | r_lock | ~r_last_gnt);
    o_m0_gnt    = ~i_rst & i_m0_req & ~o_m1_gnt & ~(r_lock & i_m1_lock);
    o_m0_stall  = i_m0_req & ~o_m0_gnt;
    o_mem_en    = o_m0_gnt | o_m1_gnt;
    o_mem_we    = o_m1_gnt ? i_m1_we : o_m0_gnt & i_m0_we;
    o_mem_addr  = o_m1_gnt ? i_m1_addr : o_m0_gnt ? i_m0_addr : '0;
    o_mem_wdata = o_m1_gnt ? i_m1_wdata : o_m0_gnt ? i_m0_wdata : '0;
    o_m0_rvalid = ~i_rst & r_rd_pend & ~r_rd_owner;
    o_m1_rvalid = ~i_rst & r_rd_pend & r_rd_owner;
    o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_gnt <= 1'b1;
      r_lock     <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      if (o_mem_en) r_last_gnt <= o_m1_gnt;
      r_lock    <= i_m1_lock & (o_m1_gnt | r_lock);
      r_rd_pend <= o_mem_en & ~o_mem_we;
      if (o_mem_en & ~o_mem_we) r_rd_owner <= o_m1_gnt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed check of dmem_arbiter against a rule-level reference model
module tb_dmem_arbiter;
  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rd;
  logic [31:0] mem [256];
  logic [31:0] gold [256];
  int          n_chk, n_err;
  bit          m_last, m_lock, p_valid, p_owner;
  logic [31:0] p_data;
  logic        ob_g0, ob_g1, ob_rv0, ob_rv1;
  logic [31:0] ob_rd0;
  dmem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_lock(m1_lock),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt), .o_m0_rvalid(m0_rvalid), .o_m1_rvalid(m1_rvalid),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata), .o_m0_stall(m0_stall),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rd)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rd <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask
  task automatic step();
    bit e0, e1, e_we;
    logic [7:0] e_addr;
    logic [31:0] e_wd;
    @(negedge clk);
    e0 = 0;
    e1 = 0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (m_lock || !m_last) e1 = 1; else e0 = 1;
      end else if (m1_req) e1 = 1;
      else if (m0_req && !(m_lock && m1_lock)) e0 = 1;
    end
    e_we   = e1 ? m1_we : (e0 && m0_we);
    e_addr = e1 ? m1_addr : e0 ? m0_addr : 8'h0;
    e_wd   = e1 ? m1_wdata : e0 ? m0_wdata : 32'h0;
    check("gnt0", m0_gnt, e0);
    check("gnt1", m1_gnt, e1);
    check("stall", m0_stall, m0_req && !e0);
    check("mem_en", mem_en, e0 || e1);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("rvalid0", m0_rvalid, p_valid && !rst && !p_owner);
    check("rvalid1", m1_rvalid, p_valid && !rst && p_owner);
    check("rdata0", m0_rdata, (p_valid && !rst && !p_owner) ? p_data : 32'h0);
    check("rdata1", m1_rdata, (p_valid && !rst && p_owner) ? p_data : 32'h0);
    ob_g0 = m0_gnt;
    ob_g1 = m1_gnt;
    ob_rv0 = m0_rvalid;
    ob_rv1 = m1_rvalid;
    ob_rd0 = m0_rdata;
    @(posedge clk);
    if (rst) begin
      m_last = 1;
      m_lock = 0;
      p_valid = 0;
    end else begin
      if (e0 || e1) m_last = e1;
      m_lock  = m1_lock && (e1 || m_lock);
      if ((e0 || e1) && e_we) gold[e_addr] = e_wd;
      p_valid = (e0 || e1) && !e_we;
      p_owner = e1;
      p_data  = gold[e_addr];
    end
    #1;
  endtask
  initial begin
    int cnt;
    logic [5:0] seq;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = i;
      gold[i] = i;
    end
    m_last = 1; m_lock = 0; p_valid = 0; p_owner = 0; p_data = 0;
    rst = 1; m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    step();
    step();
    rst = 0;
    repeat (10) step();
    m0_req = 1; m0_we = 1; m0_addr = 100; m0_wdata = 25;
    m1_req = 1; m1_we = 1; m1_addr = 96; m1_wdata = 7;
    step();
    check("conf_first_m0", ob_g0, 1);
    m0_req = 0;
    step();
    check("conf_second_m1", ob_g1, 1);
    m1_req = 0;
    step();
    check("mem100", mem[100], 25);
    check("mem96", mem[96], 7);
    m0_req = 1; m0_we = 0; m0_addr = 8'h19;
    step();
    m0_req = 0;
    step();
    check("rd19_valid", ob_rv0, 1);
    check("rd19_data", ob_rd0, 25);
    m0_req = 1; m0_we = 0; m0_addr = 5;
    m1_req = 1; m1_we = 0; m1_lock = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m1_addr = 8'(40 + i);
      step();
      cnt += int'(ob_g1);
    end
    check("lock_m1_grants", cnt, 4);
    m1_req = 0; m1_lock = 0;
    step();
    check("lock_release_m0", ob_g0, 1);
    m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 7;
    step();
    m1_req = 0; rst = 1;
    step();
    check("rst_drop_rvalid1", ob_rv1, 0);
    rst = 0;
    m0_req = 1; m0_we = 0; m0_addr = 10;
    m1_req = 1; m1_we = 0; m1_addr = 20;
    seq = 0;
    repeat (6) begin
      step();
      seq = {seq[4:0], ob_g1};
    end
    check("alternate", seq, 6'b010101);
    m0_req = 0; m1_req = 0;
    step();
    repeat (600) begin
      if (!m0_req || ob_g0) begin
        m0_req = $urandom_range(0, 3) != 0;
        m0_we = $urandom_range(0, 1) == 1;
        m0_addr = 8'($urandom);
        m0_wdata = $urandom;
      end
      if (!m1_req || ob_g1) begin
        m1_req = $urandom_range(0, 3) != 0;
        m1_we = $urandom_range(0, 1) == 1;
        m1_addr = 8'($urandom);
        m1_wdata = $urandom;
      end
      m1_lock = m1_req ? $urandom_range(0, 1) == 1 : $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 60) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
